// File: rtl/winddir_pkg.sv
// -----------------------------------------------------------------------------
// winddir_pkg
//   Shared definitions for the wind-direction lamp system. The lamp generator
//   and the decoder both use these codes, so they live in one place.
//
//   Pattern codes (3 lamps, MSB = left lamp):
//     OUTER = 101, INNER = 010, LEFT = 100, RIGHT = 001
//   Direction codes:
//     CALM = 00, RTL = 01 (right-to-left), LTR = 10 (left-to-right)
// -----------------------------------------------------------------------------
package winddir_pkg;

  localparam logic [2:0] PAT_OUTER = 3'b101;
  localparam logic [2:0] PAT_INNER = 3'b010;
  localparam logic [2:0] PAT_LEFT  = 3'b100;
  localparam logic [2:0] PAT_RIGHT = 3'b001;

  // Value that prev powers up with: the inner lamp.
  localparam logic [2:0] PAT_RESET = PAT_INNER;

  typedef enum logic [1:0] {
    DIR_CALM = 2'b00,
    DIR_RTL  = 2'b01,
    DIR_LTR  = 2'b10
  } dir_e;

  // EMPTY: no legal previous sample is held.
  // TRACK: prev holds the last legal sample.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  // True for the four lamp patterns the generator can legally show.
  function automatic logic is_legal_code(input logic [2:0] code);
    return (code == PAT_OUTER) || (code == PAT_INNER) ||
           (code == PAT_LEFT)  || (code == PAT_RIGHT);
  endfunction

endpackage

// File: rtl/winddir_classify.sv
// -----------------------------------------------------------------------------
// winddir_classify
//   Purely combinational classifier for one lamp-pattern step.
//
//   Ports:
//     prev             in  3  previously held legal pattern
//     pattern          in  3  pattern currently observed
//     legal_code       out 1  pattern is one of OUTER/INNER/LEFT/RIGHT
//     legal_transition out 1  prev->pattern is one of the listed transitions
//     trans_class      out 2  direction class of the transition (CALM when
//                             legal_transition is 0; callers must gate on it)
//
//   Listed transitions:
//     CALM : 010->101, 101->010
//     RTL  : 010->100, 100->001, 001->010
//     LTR  : 010->001, 001->100, 100->010
// -----------------------------------------------------------------------------
module winddir_classify
  import winddir_pkg::*;
(
  input  logic [2:0] prev,
  input  logic [2:0] pattern,
  output logic       legal_code,
  output logic       legal_transition,
  output dir_e       trans_class
);

  always_comb begin
    legal_code       = is_legal_code(pattern);
    legal_transition = 1'b0;
    trans_class      = DIR_CALM;

    unique case (prev)
      PAT_INNER: begin
        if (pattern == PAT_OUTER) begin
          legal_transition = 1'b1;
          trans_class      = DIR_CALM;
        end else if (pattern == PAT_LEFT) begin
          legal_transition = 1'b1;
          trans_class      = DIR_RTL;
        end else if (pattern == PAT_RIGHT) begin
          legal_transition = 1'b1;
          trans_class      = DIR_LTR;
        end
      end
      PAT_OUTER: begin
        if (pattern == PAT_INNER) begin
          legal_transition = 1'b1;
          trans_class      = DIR_CALM;
        end
      end
      PAT_LEFT: begin
        if (pattern == PAT_RIGHT) begin
          legal_transition = 1'b1;
          trans_class      = DIR_RTL;
        end else if (pattern == PAT_INNER) begin
          legal_transition = 1'b1;
          trans_class      = DIR_LTR;
        end
      end
      PAT_RIGHT: begin
        if (pattern == PAT_INNER) begin
          legal_transition = 1'b1;
          trans_class      = DIR_RTL;
        end else if (pattern == PAT_LEFT) begin
          legal_transition = 1'b1;
          trans_class      = DIR_LTR;
        end
      end
      default: begin
        // prev only ever holds a legal code; anything else classifies as none.
        legal_transition = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/winddir_decoder.sv
// -----------------------------------------------------------------------------
// winddir_decoder
//   Watches the lamp pattern on each tick and decodes the wind direction from
//   the sequence of pattern transitions. A direction is only published once
//   CONFIRM consecutive transitions of the same class have been seen.
//
//   Parameters:
//     CONFIRM   consecutive same-class transitions needed to update dir (1..7)
//
//   Ports:
//     clk        in  1  clock, all state changes on rising edge
//     reset      in  1  synchronous active-low reset
//     tick       in  1  sample enable for pattern
//     pattern    in  3  observed lamp pattern
//     dir        out 2  decoded direction (CALM/RTL/LTR), registered
//     dir_valid  out 1  set once any direction is confirmed, sticky to reset
//     err        out 1  one-cycle pulse on illegal code / illegal transition
//     err_cnt    out 4  saturating count of err pulses
// -----------------------------------------------------------------------------
module winddir_decoder
  import winddir_pkg::*;
#(
  parameter int unsigned CONFIRM = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [2:0] pattern,
  output logic [1:0] dir,
  output logic       dir_valid,
  output logic       err,
  output logic [3:0] err_cnt
);

  localparam logic [2:0] CONFIRM_L = 3'(CONFIRM);
  localparam logic [3:0] ERR_MAX   = 4'd15;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e     state_q,     state_d;
  logic [2:0] prev_q,      prev_d;
  dir_e       cand_q,      cand_d;
  logic [2:0] streak_q,    streak_d;
  dir_e       dir_q,       dir_d;
  logic       dir_valid_q, dir_valid_d;
  logic       err_q,       err_d;
  logic [3:0] err_cnt_q,   err_cnt_d;

  // ---------------------------------------------------------------------------
  // Classification of the current step
  // ---------------------------------------------------------------------------
  logic legal_code;
  logic legal_transition;
  dir_e trans_class;

  winddir_classify u_classify (
    .prev             (prev_q),
    .pattern          (pattern),
    .legal_code       (legal_code),
    .legal_transition (legal_transition),
    .trans_class      (trans_class)
  );

  // Streak value after a classified transition, before confirmation check.
  logic [2:0] streak_inc;
  assign streak_inc = (streak_q >= CONFIRM_L) ? CONFIRM_L : streak_q + 3'd1;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    cand_d      = cand_q;
    streak_d    = streak_q;
    dir_d       = dir_q;
    dir_valid_d = dir_valid_q;
    err_d       = 1'b0;   // err is a pulse: low unless an error happens now

    if (tick) begin
      if (!legal_code) begin
        // Garbage on the lamps: forget the history entirely and resync on
        // the next legal code. The published direction is kept.
        err_d    = 1'b1;
        streak_d = 3'd0;
        state_d  = ST_EMPTY;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            // First legal sample only establishes a reference point.
            prev_d  = pattern;
            state_d = ST_TRACK;
          end
          ST_TRACK: begin
            if (pattern == prev_q) begin
              // Lamps have not moved since the last sample; nothing to do.
            end else if (!legal_transition) begin
              // Legal code but a skipped/backward step: resync from here.
              err_d    = 1'b1;
              streak_d = 3'd0;
              prev_d   = pattern;
            end else begin
              prev_d = pattern;
              if (trans_class == cand_q) begin
                streak_d = streak_inc;
              end else begin
                cand_d   = trans_class;
                streak_d = 3'd1;
              end
              // Confirmation uses the updated streak/candidate of this edge.
              if (streak_d == CONFIRM_L) begin
                dir_d       = cand_d;
                dir_valid_d = 1'b1;
              end
            end
          end
          default: begin
            state_d = ST_EMPTY;
          end
        endcase
      end
    end

    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      prev_q      <= PAT_RESET;
      cand_q      <= DIR_CALM;
      streak_q    <= 3'd0;
      dir_q       <= DIR_CALM;
      dir_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cand_q      <= cand_d;
      streak_q    <= streak_d;
      dir_q       <= dir_d;
      dir_valid_q <= dir_valid_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign dir       = dir_q;
  assign dir_valid = dir_valid_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/winddir_decoder.md
WINDDIR_DECODER -- requirements
Module: winddir_decoder

Interface
REQ-001 Parameter CONFIRM, default 2, number of consecutive same-class transitions required before dir is updated (legal range 1..7).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
REQ-004 tick  input  1  sample enable; pattern is sampled only on posedge clk with tick=1.
REQ-005 pattern  input  3  lamp pattern under observation: OUTER=101, INNER=010, LEFT=100, RIGHT=001.
REQ-006 dir  output  2  decoded wind direction: CALM=00, RTL=01, LTR=10; 11 never driven.
REQ-007 dir_valid  output  1  high once any direction has been confirmed since reset.
REQ-008 err  output  1  one-cycle pulse on an illegal code or an illegal transition.
REQ-009 err_cnt  output  4  count of err pulses since reset, saturating at 15.

Function
REQ-010 Outputs SHALL be registered; a sample taken at edge N is reflected on the outputs immediately after edge N (1-clock latency from tick).
REQ-011 FSM states SHALL be EMPTY (no previous sample held) and TRACK (previous legal sample held in prev).
REQ-012 Transition classes (prev->pattern) SHALL be: CALM: 010->101, 101->010; RTL: 010->100, 100->001, 001->010; LTR: 010->001, 001->100, 100->010.
REQ-013 Legal code in EMPTY SHALL set prev:=pattern, go to TRACK, and leave streak, dir, err unchanged.
REQ-014 Illegal code (000, 011, 110, 111), in either state, SHALL pulse err, clear streak, go to EMPTY, and hold dir/dir_valid.
REQ-015 In TRACK, pattern==prev SHALL be ignored (no state, streak, or output change).
REQ-016 In TRACK, a legal code forming an unlisted transition (e.g. 101->100) SHALL pulse err, clear streak, set prev:=pattern, and stay in TRACK.
REQ-017 A classified transition whose class equals cand SHALL increment streak, saturating at CONFIRM; a different class SHALL set cand:=class and streak:=1; prev:=pattern in both cases.
REQ-018 When the updated streak equals CONFIRM, dir SHALL be set to cand and dir_valid set to 1 in the same edge.
REQ-019 dir_valid SHALL remain 1 until reset, regardless of later errors.
REQ-020 err SHALL be 0 on every edge without an error event, including edges with tick=0.
REQ-021 err_cnt SHALL increment by 1 per err pulse and hold at 15 thereafter.
REQ-022 With tick=0, all state and outputs SHALL hold, except that err SHALL be 0.

Reset
REQ-023 reset=0 at an edge SHALL force: state EMPTY, prev=010, cand=CALM, streak=0, dir=00, dir_valid=0, err=0, err_cnt=0.
REQ-024 reset SHALL take priority over tick; a reset mid-sequence discards all partial streak history.

Structure
REQ-025 Package winddir_pkg SHALL hold the pattern codes (OUTER, INNER, LEFT, RIGHT) and dir codes (CALM, RTL, LTR), shared with the winddir lamp generator.
REQ-026 Combinational sub-module winddir_classify SHALL map (prev, pattern) to {legal_code, legal_transition, class}; winddir_decoder instantiates it once.

Verification
REQ-027 Reset, then tick=1 each cycle with pattern 010,101,010 -> dir=00, dir_valid=1 after the third sample; err_cnt=0.
REQ-028 Pattern 010,100,001,010,100 -> dir=01 after the 001 sample (second RTL transition); dir stays 01 through the rest.
REQ-029 After REQ-028, pattern 001,100,010 -> dir changes 01->10 only after the 010 sample (second LTR transition).
REQ-030 Pattern 010,011,010 -> err pulses exactly one cycle after the 011 sample, err_cnt=1, dir unchanged; the following 010 yields no err.
REQ-031 Pattern 010, held for 5 tick cycles, then 101 with tick=0 for 3 cycles -> no output change; 17 illegal samples -> err_cnt=15.
REQ-032 Drive reset=0 one cycle after 010,100 (streak=1), release, then 100,001 -> the first 100 only loads prev; dir_valid remains 0 until a second RTL transition completes.
